// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: Sel encodings,
// default geometry, stage-count derivation and signed max/min constants.
package pipelined_add_sub_pkg;

    typedef enum logic {
        SEL_ADD = 1'b0,
        SEL_SUB = 1'b1
    } sel_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Constants are built 64 bits wide; callers keep the low WIDTH bits.
    function automatic logic [63:0] signed_max(input int width);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < width - 1; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [63:0] signed_min(input int width);
        logic [63:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipelined_add_sub_stage.sv
// One CHUNK-bit slice of the pipelined adder: combinational slice sum,
// registered carry to the next slice and a registered valid bit.
module add_sub_stage
    import pipelined_add_sub_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_i,
    input  logic             valid_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             carry_q_o,
    output logic             valid_q_o
);

    logic [CHUNK:0] total;
    logic           carry_q;
    logic           valid_q;

    assign total = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
    assign sum_o = total[CHUNK-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            carry_q <= total[CHUNK];
            valid_q <= valid_i;
        end
    end

    assign carry_q_o = carry_q;
    assign valid_q_o = valid_q;

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK slice per stage, valid/ready
// on both sides. Define ADD_SUB_SATURATE_EN to clamp S on signed overflow.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int NDLY   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

`ifdef ADD_SUB_SATURATE_EN
    localparam logic [63:0]      SMAX_64    = signed_max(WIDTH);
    localparam logic [63:0]      SMIN_64    = signed_min(WIDTH);
    localparam logic [WIDTH-1:0] SIGNED_MAX = SMAX_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SIGNED_MIN = SMIN_64[WIDTH-1:0];
`endif

    logic             adv;

    // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] bs_d    [STAGES];
    logic [WIDTH-1:0] lo_d    [STAGES];
    logic             cin_d   [STAGES];
    logic             vld_d   [STAGES];
    logic [WIDTH-1:0] lo_next [STAGES];

    logic [CHUNK-1:0] sum_slice [STAGES];
    logic             carry_q   [STAGES];
    logic             vld_q     [STAGES];

    logic [WIDTH-1:0] a_q  [NDLY];
    logic [WIDTH-1:0] bs_q [NDLY];
    logic [WIDTH-1:0] lo_q [NDLY];

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] s_d;
    logic             v_d;
    logic             z_d;
    logic [WIDTH-1:0] s_q;
    logic             v_q;
    logic             z_q;

    // One global enable: the whole pipe moves only when the output slot frees up.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        a_d[0]   = A;
        bs_d[0]  = B ^ {WIDTH{Sel == SEL_SUB}};
        lo_d[0]  = '0;
        cin_d[0] = Cin;
        vld_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            bs_d[k]  = bs_q[k-1];
            lo_d[k]  = lo_q[k-1];
            cin_d[k] = carry_q[k-1];
            vld_d[k] = vld_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            lo_next[k] = lo_d[k];
            lo_next[k][k*CHUNK +: CHUNK] = sum_slice[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_sub_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (adv),
            .a_i       (a_d[k][k*CHUNK +: CHUNK]),
            .b_i       (bs_d[k][k*CHUNK +: CHUNK]),
            .carry_i   (cin_d[k]),
            .valid_i   (vld_d[k]),
            .sum_o     (sum_slice[k]),
            .carry_q_o (carry_q[k]),
            .valid_q_o (vld_q[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NDLY; k++) begin
                a_q[k]  <= '0;
                bs_q[k] <= '0;
                lo_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k]  <= a_d[k];
                bs_q[k] <= bs_d[k];
                lo_q[k] <= lo_next[k];
            end
        end
    end

    // Overflow is judged on the raw sum; any clamp happens afterwards.
    always_comb begin
        raw_sum = lo_next[LAST];
        v_d     = (a_d[LAST][MSB] == bs_d[LAST][MSB]) && (raw_sum[MSB] != a_d[LAST][MSB]);
        s_d     = raw_sum;
`ifdef ADD_SUB_SATURATE_EN
        if (v_d) begin
            s_d = a_d[LAST][MSB] ? SIGNED_MIN : SIGNED_MAX;
        end
`endif
        z_d     = (s_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (adv) begin
            s_q <= s_d;
            v_q <= v_d;
            z_q <= z_d;
        end
    end

    assign S         = s_q;
    assign V         = v_q;
    assign Z         = z_q;
    assign Cout      = carry_q[LAST];
    assign out_valid = vld_q[LAST];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=16, CHUNK=4): directed
// cases, stall/reset scenarios and a random sweep against an arithmetic model.
module tb_pipelined_add_sub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Sel;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;
    logic        V;
    logic        Z;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   total    = 0;
    int   bad      = 0;
    int   accs     = 0;
    int   outs     = 0;
    int   run      = 0;
    int   max_run  = 0;
    bit   last_acc = 0;

`ifdef ADD_SUB_SATURATE_EN
    localparam logic [15:0] T3A_S = 16'h7FFF;
    localparam logic [15:0] T3B_S = 16'h8000;
`else
    localparam logic [15:0] T3A_S = 16'h8000;
    localparam logic [15:0] T3B_S = 16'h7FFF;
`endif

    pipelined_add_sub #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .V         (V),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sel, input logic cin);
        exp_t        m;
        logic [15:0] bs;
        longint      u;
        int          sa;
        bs  = sel ? ~b : b;
        u   = longint'(a) + longint'(bs) + longint'(cin);
        sa  = int'($signed(a)) + int'($signed(bs)) + int'(cin);
        m.s = u[15:0];
        m.c = (u >= 65536);
        m.v = (sa > 32767) || (sa < -32768);
`ifdef ADD_SUB_SATURATE_EN
        if (m.v) m.s = (sa > 0) ? 16'h7FFF : 16'h8000;
`endif
        m.z = (m.s == 16'h0000);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, score consumed outputs, record accepts.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_out observed S=%0h expected no output", S);
            end else begin
                e = q.pop_front();
                chk("sb_S", S, e.s);
                chk("sb_Cout", Cout, e.c);
                chk("sb_V", V, e.v);
                chk("sb_Z", Z, e.z);
            end
            outs++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (last_acc) begin
            q.push_back(model(A, B, Sel, Cin));
            accs++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_rand();
        A   = pick();
        B   = pick();
        Sel = 1'($urandom_range(0, 1));
        Cin = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int g;
        g = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && g < 40) begin
            tick();
            g++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic dir_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sel, input logic cin, input logic [15:0] es,
                          input logic ec, input logic ev, input logic ez);
        int lat;
        bit seen;
        A = a; B = b; Sel = sel; Cin = cin;
        in_valid = 1'b1;
        tick();
        chk({tag, "_acc"}, last_acc, 1);
        in_valid = 1'b0;
        lat  = 1;
        seen = 0;
        while (!seen && lat < 20) begin
            if (out_valid) seen = 1;
            else begin
                tick();
                lat++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed no out_valid expected within 4 cycles", tag);
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_S"}, S, es);
        chk({tag, "_Cout"}, Cout, ec);
        chk({tag, "_V"}, V, ev);
        chk({tag, "_Z"}, Z, ez);
        tick();
    endtask

    initial begin
        int sent;
        int guard;
        bit stalled;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Sel = 1'b0; Cin = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_Cout", Cout, 0);
        chk("rst_V", V, 0);
        chk("rst_Z", Z, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_in_ready", in_ready, 1);

        // Directed arithmetic cases
        dir_op("t1", 16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b0);
        dir_op("t2a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        dir_op("t2b", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        dir_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, T3A_S, 1'b0, 1'b1, 1'b0);
        dir_op("t3b", 16'h8000, 16'h0001, 1'b1, 1'b1, T3B_S, 1'b1, 1'b1, 1'b0);

        // Eight back-to-back ops
        drain();
        run = 0; max_run = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_rand();
            tick();
            chk("b2b_acc", last_acc, 1);
        end
        drain();
        chk("b2b_run", max_run, 8);

        // Continuous stream with a 3-cycle output stall in the middle
        sent = 0; guard = 0; stalled = 0;
        in_valid = 1'b1;
        set_rand();
        while (sent < 12 && guard < 100) begin
            if (sent == 6 && !stalled) begin
                stalled = 1;
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_hold_S", S, (q.size() != 0) ? q[0].s : 16'hxxxx);
                end
                out_ready = 1'b1;
            end
            tick();
            guard++;
            if (last_acc) begin
                sent++;
                set_rand();
            end
        end
        chk("stream_sent", sent, 12);
        drain();
        chk("stream_count", outs, accs);

        // Random sweep with random valid/ready
        for (int i = 0; i < 300; i++) begin
            set_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        out_ready = 1'b1;
        drain();
        chk("rand_count", outs, accs);

        // Reset with ops in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 16'h1111; B = 16'h2222; Sel = 1'b0; Cin = 1'b0;
        tick();
        chk("r_acc0", last_acc, 1);
        A = 16'h0F0F; B = 16'h0101;
        tick();
        chk("r_acc1", last_acc, 1);
        A = 16'h4000; B = 16'h0001; Sel = 1'b1; Cin = 1'b1;
        tick();
        chk("r_acc2", last_acc, 1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("r_pre_valid", out_valid, 1);
        chk("r_pre_S", S, 16'h3333);
        #2 rst = 1'b1;
        #1;
        chk("r_out_valid", out_valid, 0);
        chk("r_S", S, 0);
        chk("r_Cout", Cout, 0);
        chk("r_V", V, 0);
        chk("r_Z", Z, 0);
        q.delete();
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("r_rel_in_ready", in_ready, 1);
        repeat (6) tick();
        chk("r_no_ghost", out_valid, 0);
        dir_op("t5", 16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
